uart_tx: RTL and testbench

UART transmit engine sitting directly downstream of the TX data and control registers.
- Consumes the TX data byte, baud divisor and frame configuration held in those registers.
- Serialises one frame per start request onto tx_o.
- Writes status back through the registers' peripheral write port: a start-clear pulse and a done pulse.

---
 rtl/uart_tx_pkg.sv | 24 ++
 rtl/uart_baud_tick.sv | 35 +++
 rtl/uart_tx.sv | 146 ++++++++++++++
 tb/tb_uart_tx.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_tx_pkg;

  // Frame sequencer states; encodings are visible to software debug readback.
  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
    StParity = 3'd3,
    StStop   = 3'd4
  } uart_state_e;

  // Bit positions of the frame fields in the control register.
  localparam int unsigned CtrlStartBit     = 0;
  localparam int unsigned CtrlParityEnBit  = 1;
  localparam int unsigned CtrlParityOddBit = 2;
  localparam int unsigned CtrlStop2Bit     = 3;

  // Parity over up to 8 data bits; narrower words are zero-extended by the caller.
  function automatic logic calc_parity(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period divisor: counts 0..div-1 and ticks on the last cycle of each period.
// A divisor of 0 behaves as 1 (tick every cycle).
module uart_baud_tick #(
  parameter int unsigned DIV_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 restart_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  output logic                 tick_o
);

  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0] last_cnt;

  // Terminal count and next count; restart holds the period at its first cycle.
  always_comb begin
    last_cnt = (div_i == '0) ? '0 : div_i - 1'b1;
    tick_o   = (cnt_q == last_cnt);
    cnt_d    = cnt_q + 1'b1;
    if (restart_i || tick_o) begin
      cnt_d = '0;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmit engine: latches the TX registers on acceptance and serialises one frame.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DIV_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  tx_start_i,
  input  logic [DATA_WIDTH-1:0] tx_data_i,
  input  logic [DIV_WIDTH-1:0]  baud_div_i,
  input  logic                  parity_en_i,
  input  logic                  parity_odd_i,
  input  logic                  stop2_i,
  output logic                  tx_o,
  output logic                  busy_o,
  output logic                  start_clr_o,
  output logic                  done_o
);

  // DATA_WIDTH is limited to 5..8, so a 3-bit index always suffices.
  localparam logic [2:0] LastIdx = 3'(DATA_WIDTH - 1);

  uart_state_e           state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DIV_WIDTH-1:0]  div_q, div_d;
  logic                  par_en_q, par_en_d;
  logic                  par_bit_q, par_bit_d;
  logic                  stop2_q, stop2_d;
  logic [2:0]            bit_idx_q, bit_idx_d;
  logic                  tick;
  logic                  start_clr;
  logic                  done;

  // Bit timer is held at zero while idle so the start bit gets a full period.
  uart_baud_tick #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_baud_tick (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .restart_i (state_q == StIdle),
    .div_i     (div_q),
    .tick_o    (tick)
  );

  // Frame sequencing and input latching.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    div_d     = div_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    stop2_d   = stop2_q;
    bit_idx_d = bit_idx_q;
    start_clr = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (tx_start_i) begin
          start_clr = 1'b1;
          state_d   = StStart;
          shift_d   = tx_data_i;
          div_d     = baud_div_i;
          par_en_d  = parity_en_i;
          par_bit_d = calc_parity(8'(tx_data_i), parity_odd_i);
          stop2_d   = stop2_i;
          bit_idx_d = '0;
        end
      end
      StStart: begin
        if (tick) begin
          state_d   = StData;
          bit_idx_d = '0;
        end
      end
      StData: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          if (bit_idx_q == LastIdx) begin
            bit_idx_d = '0;
            state_d   = par_en_q ? StParity : StStop;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      StParity: begin
        if (tick) begin
          state_d = StStop;
        end
      end
      StStop: begin
        // bit_idx counts stop bits here; a second period runs only when stop2 is latched.
        if (tick) begin
          if (stop2_q && (bit_idx_q == 3'd0)) begin
            bit_idx_d = 3'd1;
          end else begin
            bit_idx_d = '0;
            state_d   = StIdle;
            done      = 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Serial line and status outputs; pulses are suppressed while reset is applied.
  always_comb begin
    tx_o = 1'b1;
    unique case (state_q)
      StStart:  tx_o = 1'b0;
      StData:   tx_o = shift_q[0];
      StParity: tx_o = par_bit_q;
      default:  tx_o = 1'b1;
    endcase
    busy_o      = (state_q != StIdle);
    start_clr_o = start_clr & ~rst_i;
    done_o      = done & ~rst_i;
  end

  // State and latched-configuration registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      div_q     <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      stop2_q   <= 1'b0;
      bit_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      div_q     <= div_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      stop2_q   <= stop2_d;
      bit_idx_q <= bit_idx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: directed scenarios plus randomized frames vs a frame model.
module tb_uart_tx;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        tx_start_i;
  logic [7:0]  tx_data_i;
  logic [15:0] baud_div_i;
  logic        parity_en_i;
  logic        parity_odd_i;
  logic        stop2_i;
  logic        tx_o;
  logic        busy_o;
  logic        start_clr_o;
  logic        done_o;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  uart_tx #(
    .DATA_WIDTH (8),
    .DIV_WIDTH  (16)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .tx_start_i   (tx_start_i),
    .tx_data_i    (tx_data_i),
    .baud_div_i   (baud_div_i),
    .parity_en_i  (parity_en_i),
    .parity_odd_i (parity_odd_i),
    .stop2_i      (stop2_i),
    .tx_o         (tx_o),
    .busy_o       (busy_o),
    .start_clr_o  (start_clr_o),
    .done_o       (done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; checks the line is idle for n cycles with no request.
  task automatic idle_check(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      tx_start_i = 1'b0;
      #1;
      chk({tag, "_tx"}, 32'(tx_o), 32'd1);
      chk({tag, "_busy"}, 32'(busy_o), 32'd0);
      chk({tag, "_clr"}, 32'(start_clr_o), 32'd0);
      chk({tag, "_done"}, 32'(done_o), 32'd0);
      @(negedge clk_i);
    end
  endtask

  // Called at a negedge of an idle cycle. Requests a frame and checks every cycle of it
  // against the expected bit list. hold keeps tx_start_i high; chg rewrites the inputs
  // at frame cycle 10. Returns at the negedge of the idle cycle after the frame.
  task automatic do_frame(input logic [7:0] d, input logic [15:0] div, input logic pe,
                          input logic po, input logic s2, input bit hold, input bit chg,
                          input string tag);
    bit          bits[$];
    int unsigned deff;
    int unsigned n;
    tx_data_i    = d;
    baud_div_i   = div;
    parity_en_i  = pe;
    parity_odd_i = po;
    stop2_i      = s2;
    tx_start_i   = 1'b1;
    #1;
    chk({tag, "_acc_clr"}, 32'(start_clr_o), 32'd1);
    chk({tag, "_acc_tx"}, 32'(tx_o), 32'd1);
    chk({tag, "_acc_busy"}, 32'(busy_o), 32'd0);
    chk({tag, "_acc_done"}, 32'(done_o), 32'd0);
    bits.push_back(1'b0);
    for (int k = 0; k < 8; k++) bits.push_back(((d >> k) & 8'd1) != 0);
    if (pe) begin
      int ones = 0;
      for (int k = 0; k < 8; k++) ones += int'((d >> k) & 8'd1);
      bits.push_back(((ones % 2) == 1) ^ po);
    end
    bits.push_back(1'b1);
    if (s2) bits.push_back(1'b1);
    deff = (div == 16'd0) ? 1 : int'(div);
    n    = deff * bits.size();
    for (int i = 0; i < int'(n); i++) begin
      @(negedge clk_i);
      if (!hold) tx_start_i = 1'b0;
      if (chg && i == 10) begin
        baud_div_i = 16'd8;
        tx_data_i  = 8'h3C;
      end
      #1;
      chk($sformatf("%s_tx_c%0d", tag, i), 32'(tx_o), 32'(bits[i / deff]));
      chk($sformatf("%s_busy_c%0d", tag, i), 32'(busy_o), 32'd1);
      chk($sformatf("%s_done_c%0d", tag, i), 32'(done_o), 32'(i == int'(n) - 1));
      chk($sformatf("%s_clr_c%0d", tag, i), 32'(start_clr_o), 32'd0);
    end
    @(negedge clk_i);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_i        = 1'b1;
    tx_start_i   = 1'b0;
    tx_data_i    = 8'h00;
    baud_div_i   = 16'd4;
    parity_en_i  = 1'b0;
    parity_odd_i = 1'b0;
    stop2_i      = 1'b0;
    repeat (3) @(negedge clk_i);
    #1;
    chk("rst_tx", 32'(tx_o), 32'd1);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_clr", 32'(start_clr_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    idle_check(2, "post_rst");

    // Basic frame, then parity/stop variants.
    do_frame(8'hA5, 16'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "basic");
    idle_check(2, "basic_idle");
    do_frame(8'hA5, 16'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "even2");
    idle_check(1, "even2_idle");
    do_frame(8'hA5, 16'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "odd1");
    idle_check(1, "odd1_idle");

    // Divisor edge: 0 and 1 both give one cycle per bit.
    do_frame(8'hFF, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "div0");
    idle_check(1, "div0_idle");
    do_frame(8'hFF, 16'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "div1");
    idle_check(1, "div1_idle");

    // Back-to-back with the request held high; it drops during the second frame.
    do_frame(8'h00, 16'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "b2b_a");
    do_frame(8'h55, 16'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "b2b_b");
    idle_check(4, "b2b_idle");

    // Config change at cycle 10 must not disturb the running frame.
    do_frame(8'hA5, 16'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "chg");
    idle_check(1, "chg_idle");

    // Reset during data bit 3 (frame cycles 16..19 at div 4).
    tx_data_i  = 8'hA5;
    baud_div_i = 16'd4;
    tx_start_i = 1'b1;
    #1;
    chk("mrst_acc_clr", 32'(start_clr_o), 32'd1);
    for (int i = 0; i < 18; i++) begin
      @(negedge clk_i);
      tx_start_i = 1'b0;
    end
    rst_i = 1'b1;
    #1;
    chk("mrst_busy_before", 32'(busy_o), 32'd1);
    chk("mrst_done_during", 32'(done_o), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    chk("mrst_tx", 32'(tx_o), 32'd1);
    chk("mrst_busy", 32'(busy_o), 32'd0);
    chk("mrst_done", 32'(done_o), 32'd0);
    @(negedge clk_i);
    idle_check(2, "mrst_idle");
    do_frame(8'hA5, 16'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "mrst_after");
    idle_check(1, "mrst_after_idle");

    // Randomized frames.
    for (int r = 0; r < 8; r++) begin
      do_frame(8'($urandom), 16'($urandom_range(0, 5)), 1'($urandom), 1'($urandom),
               1'($urandom), 1'b0, 1'b0, $sformatf("rnd%0d", r));
      idle_check(1, $sformatf("rnd%0d_idle", r));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
